// File: rtl/sdram_line_buffer.sv
// Single-line write-back buffer between a host byte port and an SDRAM burst port.
// Host accesses to the resident line complete in one cycle; misses write back and refill whole lines.
module sdram_line_buffer #(
    parameter int ADDRESS_BITS = 21,
    parameter int BUS_WIDTH    = 8,
    parameter int BURST_LENGTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDRESS_BITS-1:0] h_address,
    input  logic [BUS_WIDTH-1:0]    h_wdata,
    input  logic                    h_wren,
    input  logic                    h_req,
    input  logic                    h_flush,
    output logic                    h_ready,
    output logic                    h_done,
    output logic [BUS_WIDTH-1:0]    h_rdata,
    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic                    mem_wren,
    output logic                    mem_req,
    input  logic                    mem_ready,
    input  logic                    mem_valid,
    input  logic [2:0]              mem_offset,
    output logic [BUS_WIDTH-1:0]    mem_wdata,
    input  logic [BUS_WIDTH-1:0]    mem_rdata
);

    localparam int OFFSET_BITS = $clog2(BURST_LENGTH);
    localparam int TAG_BITS    = ADDRESS_BITS - OFFSET_BITS;

    typedef enum logic [2:0] {
        S_IDLE, S_RESP, S_WB_REQ, S_WB_WAIT, S_FILL_REQ, S_FILL_WAIT
    } state_t;

    state_t state, state_next;

    logic [BUS_WIDTH-1:0]    line [BURST_LENGTH];
    logic [TAG_BITS-1:0]     tag;
    logic                    valid, dirty;
    logic [ADDRESS_BITS-1:0] req_address;
    logic [BUS_WIDTH-1:0]    req_wdata;
    logic                    req_wren, req_flush;
    logic                    beat_seen;

    logic [TAG_BITS-1:0]    h_tag, req_tag, fill_tag;
    logic [OFFSET_BITS-1:0] h_offset, req_offset, rd_offset, beat_offset;
    logic                   hit, accept, beat_fall, rd_is_read;

    assign h_tag       = h_address[ADDRESS_BITS-1:OFFSET_BITS];
    assign h_offset    = h_address[OFFSET_BITS-1:0];
    assign req_tag     = req_address[ADDRESS_BITS-1:OFFSET_BITS];
    assign req_offset  = req_address[OFFSET_BITS-1:0];
    assign beat_offset = mem_offset[OFFSET_BITS-1:0];
    assign hit         = valid && (h_tag == tag);
    assign accept      = (state == S_IDLE) && (h_req || h_flush);
    assign beat_fall   = beat_seen && !mem_valid;
    assign mem_wdata   = line[beat_offset];

    // In S_IDLE the live host inputs describe the access; afterwards the latched copy does.
    assign fill_tag   = (state == S_IDLE) ? h_tag : req_tag;
    assign rd_offset  = (state == S_IDLE) ? h_offset : req_offset;
    assign rd_is_read = (state == S_IDLE) ? (h_req && !h_wren) : (!req_flush && !req_wren);

    always_comb begin
        state_next = state;
        h_ready    = 1'b0;
        h_done     = 1'b0;
        mem_req    = 1'b0;
        case (state)
            S_IDLE: begin
                h_ready = 1'b1;
                if (h_req) begin
                    if (hit)
                        state_next = S_RESP;
                    else if (valid && dirty)
                        state_next = S_WB_REQ;
                    else
                        state_next = S_FILL_REQ;
                end else if (h_flush) begin
                    state_next = dirty ? S_WB_REQ : S_RESP;
                end
            end
            S_RESP: begin
                h_done     = 1'b1;
                state_next = S_IDLE;
            end
            S_WB_REQ: begin
                mem_req = 1'b1;
                if (mem_ready)
                    state_next = S_WB_WAIT;
            end
            S_WB_WAIT: begin
                if (beat_fall)
                    state_next = req_flush ? S_RESP : S_FILL_REQ;
            end
            S_FILL_REQ: begin
                mem_req = 1'b1;
                if (mem_ready)
                    state_next = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                if (beat_fall)
                    state_next = S_RESP;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            valid       <= 1'b0;
            dirty       <= 1'b0;
            tag         <= '0;
            h_rdata     <= '0;
            mem_address <= '0;
            mem_wren    <= 1'b0;
            req_address <= '0;
            req_wdata   <= '0;
            req_wren    <= 1'b0;
            req_flush   <= 1'b0;
            beat_seen   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                req_address <= h_address;
                req_wdata   <= h_wdata;
                req_wren    <= h_wren;
                req_flush   <= !h_req;
            end
            // Remembers that the data phase has started so its falling edge can be recognised.
            beat_seen <= ((state == S_WB_WAIT) || (state == S_FILL_WAIT)) &&
                         !beat_fall && (beat_seen || mem_valid);
            if (state_next == S_WB_REQ && state != S_WB_REQ) begin
                mem_address <= {tag, {OFFSET_BITS{1'b0}}};
                mem_wren    <= 1'b1;
            end
            if (state_next == S_FILL_REQ && state != S_FILL_REQ) begin
                mem_address <= {fill_tag, {OFFSET_BITS{1'b0}}};
                mem_wren    <= 1'b0;
            end
            // Read data is captured on entry to S_RESP so it is valid during the h_done cycle.
            if (state_next == S_RESP && state != S_RESP && rd_is_read)
                h_rdata <= line[rd_offset];
            case (state)
                S_RESP: begin
                    if (!req_flush && req_wren)
                        dirty <= 1'b1;
                end
                S_WB_WAIT: begin
                    if (beat_fall)
                        dirty <= 1'b0;
                end
                S_FILL_REQ: begin
                    if (mem_ready)
                        valid <= 1'b0;
                end
                S_FILL_WAIT: begin
                    if (beat_fall) begin
                        tag   <= req_tag;
                        valid <= 1'b1;
                        dirty <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == S_RESP && !req_flush && req_wren)
                line[req_offset] <= req_wdata;
            else if (state == S_FILL_WAIT && mem_valid)
                line[beat_offset] <= mem_rdata;
        end
    end

endmodule

// File: doc/sdram_line_buffer.md
Name: sdram_line_buffer

Overview:
- Single-line write-back buffer between the host-side byte port (programmer command engine) and the SDRAM controller's burst port.
- Turns random byte reads and writes into whole-line SDRAM bursts of BURST_LENGTH beats.
- Serves repeated accesses to the same line without touching SDRAM.
- Holds one line (BURST_LENGTH bytes) with a tag, a valid bit and a dirty bit.

Parameters:
- ADDRESS_BITS, 21, byte address width; same on the host and memory sides.
- BUS_WIDTH, 8, data width of one beat and one host access.
- BURST_LENGTH, 8, beats per line; power of two; OFFSET_BITS = $clog2(BURST_LENGTH).

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- h_address  in  ADDRESS_BITS  host byte address.
- h_wdata  in  BUS_WIDTH  host write data.
- h_wren  in  1  1 = write, 0 = read.
- h_req  in  1  access request.
- h_flush  in  1  write-back request; h_req has priority if both are high.
- h_ready  out  1  block can accept h_req or h_flush this cycle.
- h_done  out  1  one-cycle completion pulse.
- h_rdata  out  BUS_WIDTH  read result; valid while h_done=1 for a read.
- mem_address  out  ADDRESS_BITS  line address; low OFFSET_BITS always 0.
- mem_wren  out  1  burst direction.
- mem_req  out  1  burst request to the controller.
- mem_ready  in  1  controller can accept mem_req this cycle.
- mem_valid  in  1  data-phase strobe.
- mem_offset  in  3  beat index of the current data-phase cycle.
- mem_wdata  out  BUS_WIDTH  equals line[mem_offset] combinationally at all times.
- mem_rdata  in  BUS_WIDTH  read beat data.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=S_IDLE; valid=0, dirty=0; h_ready=1, h_done=0, h_rdata=0.
  - mem_req=0, mem_wren=0, mem_address=0.
  - Reset mid-burst abandons the burst; dirty data is lost; later mem_valid pulses are ignored until the next issued request.
- Hit: valid=1 and h_address[ADDRESS_BITS-1:OFFSET_BITS]==tag.
- Acceptance: on a cycle with h_ready=1 and (h_req or h_flush), latch address, wdata and wren; h_ready drops the next cycle.
- States:
  - S_IDLE:
    - h_req hit -> S_RESP.
    - h_req miss with valid&dirty -> S_WB_REQ.
    - h_req miss otherwise -> S_FILL_REQ.
    - h_flush with dirty -> S_WB_REQ.
    - h_flush clean -> S_RESP.
  - S_RESP: 1 cycle.
    - Read: h_rdata <= line[offset].
    - Write: line[offset] <= wdata, dirty <= 1.
    - h_done=1 this cycle; -> S_IDLE, h_ready=1 the following cycle.
    - Hit latency: accept edge N, h_done high in cycle N+1, next accept possible at N+2.
  - S_WB_REQ: mem_req=1, mem_wren=1, mem_address={tag,0}; hold until mem_ready=1, drop mem_req on the next edge -> S_WB_WAIT.
  - S_WB_WAIT:
    - Wait for a mem_valid rising edge, then its falling edge; line contents must not change meanwhile.
    - On the fall: dirty <= 0.
    - Flush: -> S_RESP (h_done, no data effect).
    - Miss: -> S_FILL_REQ.
  - S_FILL_REQ: as S_WB_REQ with mem_wren=0 and the new line address -> S_FILL_WAIT.
  - S_FILL_WAIT:
    - Each cycle with mem_valid=1: line[mem_offset] <= mem_rdata.
    - On the mem_valid falling edge: tag <= new tag, valid <= 1, dirty <= 0 -> S_RESP.
    - Write miss merge happens in S_RESP (write-allocate).
- mem_req is never high outside S_WB_REQ and S_FILL_REQ. mem_req and mem_ready high together on an edge means the request is accepted.
- mem_valid in S_IDLE or S_RESP is ignored; the line is not modified.
- h_req or h_flush while h_ready=0 is ignored (not queued).
- Address arithmetic: offset = h_address[OFFSET_BITS-1:0]. Writing any byte sets dirty for the whole line; the whole line is written back.

Test Plan:
- Reset, then read 0x000013 -> write-back skipped; fill request at mem_address 0x000010, mem_wren=0; after the 8 beats (0xA0..0xA7), h_done with h_rdata=0xA3.
- Read 0x000015 right after -> h_done exactly 1 cycle after acceptance, h_rdata=0xA5, mem_req stays 0.
- Write 0x55 to 0x000011, then read 0x000011 -> both hits; rdata=0x55; no SDRAM traffic.
- Read 0x000020 with the line dirty -> write burst to 0x000010 with mem_wdata at offset 1 = 0x55, then fill from 0x000020; mem_req only after the write-burst mem_valid falls.
- h_flush on a clean line -> h_done in 1 cycle, no mem_req. h_flush on a dirty line -> one write burst, then dirty=0.
- Assert rst_n=0 mid-fill (after beat 3) -> mem_req=0, h_ready=1 next cycle; a following read of the same line misses and refills.
